// File: rtl/serial_ifetch.sv
// Byte-serial instruction fetch: four little-endian byte reads from a synchronous
// program memory assemble one 32-bit instruction, which is registered and R-type decoded.
module serial_ifetch #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              fetch_req,
  output logic              fetch_busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic              misalign_err,
  output logic [6:0]        opcode,
  output logic [4:0]        rd,
  output logic [2:0]        funct3,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [6:0]        funct7,
  output logic              is_rtype,
  output logic [CNT_W-1:0]  fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [6:0]        OP_RTYPE = 7'b0110011;

  state_t              state_q;
  logic [1:0]          k_q;
  logic [23:0]         buf_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_rd_q;
  logic                busy_q;
  logic [31:0]         instr_q;
  logic                valid_q;
  logic                misalign_q;
  logic [CNT_W-1:0]    cnt_q;

  // Handshake: fetch_req is a level sampled only in IDLE; a request seen while
  // busy is dropped, and each accepted request yields exactly one instr_valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      buf_q      <= 24'd0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      instr_q    <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fetch_req) begin
            if (pc_addr[1:0] == 2'b00) begin
              state_q    <= READ;
              k_q        <= 2'd0;
              mem_addr_q <= pc_addr;
              mem_rd_q   <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              misalign_q <= 1'b1;
            end
          end
        end
        READ: begin
          // Data for read k-1 arrives while read k is being issued.
          case (k_q)
            2'd1:    buf_q[7:0]   <= mem_rdata;
            2'd2:    buf_q[15:8]  <= mem_rdata;
            2'd3:    buf_q[23:16] <= mem_rdata;
            default: ;
          endcase
          k_q <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_q  <= DRAIN;
            mem_rd_q <= 1'b0;
          end else begin
            mem_addr_q <= mem_addr_q + ADDR_ONE;
          end
        end
        DRAIN: begin
          instr_q <= {mem_rdata, buf_q};
          valid_q <= 1'b1;
          cnt_q   <= cnt_q + CNT_ONE;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          mem_rd_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_busy   = busy_q;
  assign mem_rd       = mem_rd_q;
  assign mem_addr     = mem_addr_q;
  assign instr_valid  = valid_q;
  assign instr        = instr_q;
  assign misalign_err = misalign_q;
  assign fetch_cnt    = cnt_q;

  assign opcode   = instr_q[6:0];
  assign rd       = instr_q[11:7];
  assign funct3   = instr_q[14:12];
  assign rs1      = instr_q[19:15];
  assign rs2      = instr_q[24:20];
  assign funct7   = instr_q[31:25];
  assign is_rtype = (instr_q[6:0] == OP_RTYPE);

endmodule

// File: tb/tb_serial_ifetch.sv
// Directed bench for serial_ifetch: table of single fetches plus hand-written
// sequences for back-to-back, misaligned, reset-abort and address-wrap cases.
module tb_serial_ifetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_addr;
  logic        fetch_req;
  logic        fetch_busy;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        misalign_err;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic        is_rtype;
  logic [15:0] fetch_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_cnt;
  logic [31:0] exp_instr;

  typedef struct {
    logic [31:0] pc;
    logic        toggle;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic        rtype;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  serial_ifetch #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_addr      (pc_addr),
    .fetch_req    (fetch_req),
    .fetch_busy   (fetch_busy),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .misalign_err (misalign_err),
    .opcode       (opcode),
    .rd           (rd),
    .funct3       (funct3),
    .rs1          (rs1),
    .rs2          (rs2),
    .funct7       (funct7),
    .is_rtype     (is_rtype),
    .fetch_cnt    (fetch_cnt)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'hB3;
      32'h0000_0001: return 8'h00;
      32'h0000_0002: return 8'h52;
      32'h0000_0003: return 8'h00;
      32'h0000_0004: return 8'h33;
      32'h0000_0005: return 8'h81;
      32'h0000_0006: return 8'h20;
      32'h0000_0007: return 8'h40;
      32'h0000_0008: return 8'h13;
      32'hFFFF_FFFC: return 8'hEF;
      32'hFFFF_FFFD: return 8'hBE;
      32'hFFFF_FFFE: return 8'hAD;
      32'hFFFF_FFFF: return 8'hDE;
      default:       return 8'h00;
    endcase
  endfunction

  // Synchronous-read program memory model
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_byte(mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_quiet(input string tag);
    check({tag, ".mem_rd"}, 32'(mem_rd), 32'd0);
    check({tag, ".busy"}, 32'(fetch_busy), 32'd0);
    check({tag, ".valid"}, 32'(instr_valid), 32'd0);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    string t;
    v = vecs[i];
    t = $sformatf("v%0d", i);
    pc_addr   = v.pc;
    fetch_req = 1'b1;
    tick();
    if (!v.toggle) fetch_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s.c%0d.mem_rd", t, k + 1), 32'(mem_rd), 32'd1);
      check($sformatf("%s.c%0d.mem_addr", t, k + 1), mem_addr, v.pc + 32'(k));
      check($sformatf("%s.c%0d.busy", t, k + 1), 32'(fetch_busy), 32'd1);
      check($sformatf("%s.c%0d.valid", t, k + 1), 32'(instr_valid), 32'd0);
      if (v.toggle) fetch_req = (k % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    fetch_req = 1'b0;
    check({t, ".c5.mem_rd"}, 32'(mem_rd), 32'd0);
    check({t, ".c5.busy"}, 32'(fetch_busy), 32'd1);
    check({t, ".c5.valid"}, 32'(instr_valid), 32'd0);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check({t, ".c6.valid"}, 32'(instr_valid), 32'd1);
    check({t, ".c6.busy"}, 32'(fetch_busy), 32'd0);
    check({t, ".instr"}, instr, v.instr);
    check({t, ".opcode"}, 32'(opcode), 32'(v.opcode));
    check({t, ".rd"}, 32'(rd), 32'(v.rd));
    check({t, ".funct3"}, 32'(funct3), 32'(v.funct3));
    check({t, ".rs1"}, 32'(rs1), 32'(v.rs1));
    check({t, ".rs2"}, 32'(rs2), 32'(v.rs2));
    check({t, ".funct7"}, 32'(funct7), 32'(v.funct7));
    check({t, ".is_rtype"}, 32'(is_rtype), 32'(v.rtype));
    check({t, ".fetch_cnt"}, 32'(fetch_cnt), 32'(exp_cnt));
    exp_instr = v.instr;
    tick();
    check_idle_quiet({t, ".c7"});
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b0, 32'h0052_00B3, 7'h33, 5'd1,  3'd0, 5'd4,  5'd5,  7'h00, 1'b1};
    vecs[1] = '{32'h0000_0004, 1'b0, 32'h4020_8133, 7'h33, 5'd2,  3'd0, 5'd1,  5'd2,  7'h20, 1'b1};
    vecs[2] = '{32'hFFFF_FFFC, 1'b0, 32'hDEAD_BEEF, 7'h6F, 5'd29, 3'd3, 5'd27, 5'd10, 7'h6F, 1'b0};
    vecs[3] = '{32'h0000_0008, 1'b1, 32'h0000_0013, 7'h13, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 1'b0};

    reset     = 1'b1;
    fetch_req = 1'b0;
    pc_addr   = 32'd0;
    exp_cnt   = 16'd0;
    exp_instr = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check("rst.instr", instr, 32'd0);
    check("rst.opcode", 32'(opcode), 32'd0);
    check("rst.is_rtype", 32'(is_rtype), 32'd0);
    check("rst.fetch_cnt", 32'(fetch_cnt), 32'd0);
    check("rst.misalign", 32'(misalign_err), 32'd0);
    check_idle_quiet("rst");

    for (int i = 0; i < 4; i++) run_vec(i);

    // Back-to-back with fetch_req held: valid pulses in cycles 6 and 12
    pc_addr   = 32'h0000_0000;
    fetch_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check($sformatf("b2b.c%0d.valid", c), 32'(instr_valid), 32'((c == 6) || (c == 12)));
      if (c == 6) begin
        check("b2b.c6.instr", instr, 32'h0052_00B3);
        check("b2b.c6.busy", 32'(fetch_busy), 32'd0);
        pc_addr = 32'h0000_0004;
      end
      if (c == 7) check("b2b.c7.mem_addr", mem_addr, 32'h0000_0004);
      if (c == 12) fetch_req = 1'b0;
    end
    exp_cnt = exp_cnt + 16'd2;
    check("b2b.instr", instr, 32'h4020_8133);
    check("b2b.funct7", 32'(funct7), 32'h20);
    check("b2b.rd", 32'(rd), 32'd2);
    check("b2b.rs1", 32'(rs1), 32'd1);
    check("b2b.rs2", 32'(rs2), 32'd2);
    check("b2b.fetch_cnt", 32'(fetch_cnt), 32'(exp_cnt));
    exp_instr = 32'h4020_8133;
    tick();
    check_idle_quiet("b2b.end");

    // Misaligned request: single error pulse, no memory access
    pc_addr   = 32'h0000_0006;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("mis.c1.err", 32'(misalign_err), 32'd1);
    check_idle_quiet("mis.c1");
    for (int c = 2; c <= 7; c++) begin
      tick();
      check($sformatf("mis.c%0d.err", c), 32'(misalign_err), 32'd0);
      check_idle_quiet($sformatf("mis.c%0d", c));
    end
    check("mis.instr", instr, exp_instr);
    check("mis.fetch_cnt", 32'(fetch_cnt), 32'(exp_cnt));

    // Reset asserted in cycle 3 of a fetch aborts it
    pc_addr   = 32'h0000_0004;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 16'd0;
    check_idle_quiet("rab.c4");
    check("rab.instr", instr, 32'd0);
    check("rab.fetch_cnt", 32'(fetch_cnt), 32'd0);
    check("rab.is_rtype", 32'(is_rtype), 32'd0);
    for (int c = 5; c <= 9; c++) begin
      tick();
      check_idle_quiet($sformatf("rab.c%0d", c));
    end
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
